// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID output register and a BOOT/RUN/FLUSH
// control FSM that handles stalls, branch redirects and undefined-opcode squashing.
module fetch_unit #(
  parameter int unsigned PC_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] imem_addr,
  input  logic [15:0]     imem_data,
  output logic [15:0]     if_inst,
  output logic [PC_W-1:0] if_pc1,
  output logic            if_valid,
  output logic [15:0]     fetch_cnt
);

  typedef enum logic [1:0] {StBoot, StRun, StFlush} state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_inc;
  logic [15:0]     inst_q, inst_d;
  logic [PC_W-1:0] pc1_q, pc1_d;
  logic            valid_q, valid_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            illegal_op;

  assign pc_inc     = pc_q + PC_W'(1);
  assign illegal_op = (imem_data[15:12] >= 4'd11);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StBoot: begin
        // Single bubble after reset; branches and stalls are ignored here.
        pc_d    = '0;
        inst_d  = 16'h0000;
        valid_d = 1'b0;
        state_d = StRun;
      end
      StRun, StFlush: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          inst_d  = 16'h0000;
          valid_d = 1'b0;
          state_d = StFlush;
        end else if (!stall) begin
          if (state_q == StFlush) begin
            // Second penalty bubble; PC stays on the target so RUN fetches it next.
            inst_d  = 16'h0000;
            valid_d = 1'b0;
            state_d = StRun;
          end else begin
            pc_d  = pc_inc;
            pc1_d = pc_inc;
            if (illegal_op) begin
              inst_d  = 16'h0000;
              valid_d = 1'b0;
            end else begin
              inst_d  = imem_data;
              valid_d = 1'b1;
              if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
            end
          end
        end
      end
      default: begin
        state_d = StBoot;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StBoot;
      pc_q    <= '0;
      inst_q  <= 16'h0000;
      pc1_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr = pc_q;
  assign if_inst   = inst_q;
  assign if_pc1    = pc1_q;
  assign if_valid  = valid_q;
  assign fetch_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with a behavioural instruction memory.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic [15:0] if_inst;
  logic [7:0]  if_pc1;
  logic        if_valid;
  logic [15:0] fetch_cnt;

  logic [15:0] mem [256];
  int checks;
  int failures;

  assign imem_data = mem[imem_addr];

  fetch_unit #(.PC_W(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .if_inst      (if_inst),
    .if_pc1       (if_pc1),
    .if_valid     (if_valid),
    .fetch_cnt    (fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        br;
    logic [7:0]  tgt;
    logic [15:0] inst;
    logic        valid;
    logic        chk_pc1;
    logic [7:0]  pc1;
    logic [15:0] cnt;
    logic [7:0]  addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic b, input logic [7:0] t,
                              input logic [15:0] inst, input logic v, input logic cp,
                              input logic [7:0] p1, input logic [15:0] c,
                              input logic [7:0] a);
    vec_t r;
    r.stall = s; r.br = b; r.tgt = t; r.inst = inst; r.valid = v;
    r.chk_pc1 = cp; r.pc1 = p1; r.cnt = c; r.addr = a;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [15:0] inst, input logic v,
                           input logic cp, input logic [7:0] p1, input logic [15:0] c,
                           input logic [7:0] a);
    check({tag, ".if_inst"}, 32'(if_inst), 32'(inst));
    check({tag, ".if_valid"}, 32'(if_valid), 32'(v));
    if (cp) check({tag, ".if_pc1"}, 32'(if_pc1), 32'(p1));
    check({tag, ".fetch_cnt"}, 32'(fetch_cnt), 32'(c));
    check({tag, ".imem_addr"}, 32'(imem_addr), 32'(a));
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    mem[0]    = 16'h1012;  // ADD
    mem[1]    = 16'h2034;  // SUB
    mem[2]    = 16'h3056;  // AND
    mem[3]    = 16'h4078;  // XOR
    mem[5]    = 16'hB123;  // undefined opcode
    mem[8'h40] = 16'h8ABC;

    // stall br tgt | inst valid chk_pc1 pc1 cnt addr
    vecs.push_back(mk(0, 0, 8'h00, 16'h0000,   0, 0, 8'h00, 16'd0,  8'h00)); // BOOT
    vecs.push_back(mk(0, 0, 8'h00, mem[0],     1, 1, 8'h01, 16'd1,  8'h01));
    vecs.push_back(mk(0, 0, 8'h00, mem[1],     1, 1, 8'h02, 16'd2,  8'h02));
    vecs.push_back(mk(0, 0, 8'h00, mem[2],     1, 1, 8'h03, 16'd3,  8'h03));
    vecs.push_back(mk(1, 0, 8'h00, mem[2],     1, 1, 8'h03, 16'd3,  8'h03)); // stall x3
    vecs.push_back(mk(1, 0, 8'h00, mem[2],     1, 1, 8'h03, 16'd3,  8'h03));
    vecs.push_back(mk(1, 0, 8'h00, mem[2],     1, 1, 8'h03, 16'd3,  8'h03));
    vecs.push_back(mk(0, 0, 8'h00, mem[3],     1, 1, 8'h04, 16'd4,  8'h04));
    vecs.push_back(mk(0, 0, 8'h00, mem[4],     1, 1, 8'h05, 16'd5,  8'h05));
    vecs.push_back(mk(0, 0, 8'h00, 16'h0000,   0, 0, 8'h00, 16'd5,  8'h06)); // illegal op
    vecs.push_back(mk(0, 0, 8'h00, mem[6],     1, 1, 8'h07, 16'd6,  8'h07));
    vecs.push_back(mk(1, 1, 8'h40, 16'h0000,   0, 0, 8'h00, 16'd6,  8'h40)); // branch+stall
    vecs.push_back(mk(0, 0, 8'h00, 16'h0000,   0, 0, 8'h00, 16'd6,  8'h40)); // flush bubble
    vecs.push_back(mk(0, 0, 8'h00, mem[8'h40], 1, 1, 8'h41, 16'd7,  8'h41));
    vecs.push_back(mk(0, 0, 8'h00, mem[8'h41], 1, 1, 8'h42, 16'd8,  8'h42));
    vecs.push_back(mk(0, 1, 8'h80, 16'h0000,   0, 0, 8'h00, 16'd8,  8'h80)); // branch
    vecs.push_back(mk(1, 0, 8'h00, 16'h0000,   0, 0, 8'h00, 16'd8,  8'h80)); // stall in FLUSH
    vecs.push_back(mk(0, 1, 8'hFE, 16'h0000,   0, 0, 8'h00, 16'd8,  8'hFE)); // re-redirect
    vecs.push_back(mk(0, 0, 8'h00, 16'h0000,   0, 0, 8'h00, 16'd8,  8'hFE));
    vecs.push_back(mk(0, 0, 8'h00, mem[8'hFE], 1, 1, 8'hFF, 16'd9,  8'hFF));
    vecs.push_back(mk(0, 0, 8'h00, mem[8'hFF], 1, 1, 8'h00, 16'd10, 8'h00)); // wrap
    vecs.push_back(mk(0, 0, 8'h00, mem[0],     1, 1, 8'h01, 16'd11, 8'h01));

    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    step();
    step();
    check_all("reset", 16'h0000, 1'b0, 1'b1, 8'h00, 16'd0, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      stall         = vecs[i].stall;
      branch_taken  = vecs[i].br;
      branch_target = vecs[i].tgt;
      step();
      check_all($sformatf("vec%0d", i), vecs[i].inst, vecs[i].valid, vecs[i].chk_pc1,
                vecs[i].pc1, vecs[i].cnt, vecs[i].addr);
    end

    // Reset in the middle of FLUSH, with a competing branch and stall.
    stall = 1'b0; branch_taken = 1'b1; branch_target = 8'h20;
    step();
    check_all("pre_flush", 16'h0000, 1'b0, 1'b0, 8'h00, 16'd11, 8'h20);
    rst = 1'b1; branch_taken = 1'b1; branch_target = 8'h30; stall = 1'b1;
    step();
    check_all("rst_in_flush", 16'h0000, 1'b0, 1'b1, 8'h00, 16'd0, 8'h00);
    rst = 1'b0; branch_taken = 1'b0; stall = 1'b0;
    step();
    check_all("boot_after_rst", 16'h0000, 1'b0, 1'b0, 8'h00, 16'd0, 8'h00);
    step();
    check_all("fetch0_after_rst", mem[0], 1'b1, 1'b1, 8'h01, 16'd1, 8'h01);
    step();
    check_all("fetch1_after_rst", mem[1], 1'b1, 1'b1, 8'h02, 16'd2, 8'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
